// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU: a 2048x32 word RAM served
// combinationally to the CPU data port, plus a byte-serial loader FSM that
// fills the RAM before the CPU is released from reset.
module dmem_responder #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_r,
    input  logic              dmem_w,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] dmem_data,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        byte_cnt;
    // Bytes 0..2 of the word under assembly; unfilled bytes are kept at zero
    // so a partial word written on load_last comes out zero-padded.
    logic [DATA_W-9:0] asm_word;

    logic              accept;
    logic              full;
    logic              word_we;
    logic              cpu_we;
    logic [DATA_W-1:0] ld_word;

    assign accept  = (state == S_LOAD) && load_valid;
    assign full    = (words_loaded == (ADDR_W+1)'(DEPTH));
    assign word_we = accept && !full && ((byte_cnt == 2'd3) || load_last);
    assign cpu_we  = (state == S_RUN) && dmem_w;
    assign ld_word = {8'b0, asm_word} | (DATA_W'(load_byte) << {byte_cnt, 3'b000});

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: load_start has priority over run_start in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (load_start)     state_nxt = S_LOAD;
                else if (run_start) state_nxt = S_RUN;
            end
            S_LOAD: begin
                if (load_valid && load_last) state_nxt = S_RUN;
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        load_ready = 1'b0;
        cpu_hold   = 1'b0;
        load_done  = 1'b0;
        unique case (state)
            S_LOAD:  load_ready = 1'b1;
            S_RUN: begin
                cpu_hold  = 1'b1;
                load_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Loader counters: cleared on entry to LOAD, advanced on each accepted byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_cnt     <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
            words_loaded <= '0;
            load_err     <= 1'b0;
        end else if ((state == S_IDLE) && load_start) begin
            addr_cnt     <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
            words_loaded <= '0;
            load_err     <= 1'b0;
        end else if (accept) begin
            if (full) begin
                load_err <= 1'b1;
            end else if (word_we) begin
                asm_word     <= '0;
                byte_cnt     <= '0;
                words_loaded <= words_loaded + 1'b1;
                // Hold at the last word once the RAM is full; never wrap to 0
                if (addr_cnt != ADDR_W'(DEPTH - 1)) addr_cnt <= addr_cnt + 1'b1;
            end else begin
                asm_word <= ld_word[DATA_W-9:0];
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // RAM write port: loader in LOAD, CPU in RUN (never both); contents survive reset
    always_ff @(posedge clk) begin
        if (rst) begin
            if (word_we)     mem[addr_cnt]  <= ld_word;
            else if (cpu_we) mem[data_addr] <= w_data;
        end
    end

    // CPU read port: combinational, returns 0 unless reading in RUN
    always_comb begin
        dmem_data = '0;
        if ((state == S_RUN) && dmem_r) dmem_data = mem[data_addr];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with a word-level
// reference model of the RAM and loader results.
module tb_dmem_responder;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              dmem_r;
    logic              dmem_w;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] dmem_data;
    logic              load_start;
    logic              run_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              load_ready;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    dmem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .dmem_r(dmem_r), .dmem_w(dmem_w),
        .data_addr(data_addr), .w_data(w_data), .dmem_data(dmem_data),
        .load_start(load_start), .run_start(run_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    logic [7:0]  bq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        dmem_r = 0; dmem_w = 0; data_addr = '0; w_data = '0;
        load_start = 0; run_start = 0; load_valid = 0; load_byte = '0; load_last = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    // Stream bq into the loader with optional idle gaps and CPU-port noise,
    // then compare against the word-level expectation for that byte list.
    task automatic do_load(input int gap_pct, input bit both);
        int n;
        int nw;
        int i;
        logic [31:0] word;
        load_start = 1; run_start = both;
        tick();
        load_start = 0; run_start = 0;
        check("ready_after_start", 32'(load_ready), 32'd1);
        i = 0;
        while (i < bq.size()) begin
            load_valid = ($urandom_range(99) >= gap_pct);
            load_byte  = load_valid ? bq[i] : 8'($urandom);
            load_last  = load_valid ? (i == bq.size() - 1) : 1'($urandom);
            dmem_w     = 1'($urandom);
            dmem_r     = 1;
            data_addr  = ADDR_W'($urandom);
            w_data     = $urandom;
            #1;
            check("hold_in_load", 32'(cpu_hold), 32'd0);
            if (i % 16 == 0) check("load_rd_zero", dmem_data, 32'd0);
            tick();
            if (load_valid) i++;
        end
        quiet();
        check("done_after_last", 32'(load_done), 32'd1);
        check("hold_after_last", 32'(cpu_hold), 32'd1);
        check("ready_after_last", 32'(load_ready), 32'd0);
        n  = bq.size();
        nw = (n + 3) / 4;
        if (nw > DEPTH) nw = DEPTH;
        for (int w = 0; w < nw; w++) begin
            word = 32'd0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) word[8*k +: 8] = bq[4*w + k];
            ref_mem[w] = word;
            known[w]   = 1'b1;
        end
        check("words_loaded", 32'(words_loaded), 32'(nw));
        check("load_err", 32'(load_err), 32'(n > 4 * DEPTH));
    endtask

    task automatic verify_mem(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            if (known[a]) begin
                dmem_r = 1; data_addr = ADDR_W'(a);
                #1;
                check("mem_rd", dmem_data, ref_mem[a]);
            end
        end
        dmem_r = 0;
    endtask

    task automatic cpu_access(input bit r, input bit w, input int a, input logic [31:0] d);
        dmem_r = r; dmem_w = w; data_addr = ADDR_W'(a); w_data = d;
        #1;
        if (!r)            check("cpu_rd_off", dmem_data, 32'd0);
        else if (known[a]) check("cpu_rd", dmem_data, ref_mem[a]);
        tick();
        if (w) begin
            ref_mem[a] = d;
            known[a]   = 1'b1;
        end
        quiet();
    endtask

    task automatic run_traffic(input int n);
        int a;
        for (int c = 0; c < n; c++) begin
            case ($urandom_range(2))
                0:       a = $urandom_range(7);
                1:       a = DEPTH - 1;
                default: a = $urandom_range(DEPTH - 1);
            endcase
            cpu_access(1'($urandom), 1'($urandom), a, $urandom);
        end
    endtask

    initial begin
        rst = 1;
        quiet();
        for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;

        // Reset values
        do_reset();
        dmem_r = 1;
        #1;
        check("rst_dmem_data", dmem_data, 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        dmem_r = 0;

        // Two full words, little-endian packing
        bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load(0, 0);
        dmem_r = 1; data_addr = 0; #1; check("word0", dmem_data, 32'h12345678);
        data_addr = 1; #1; check("word1", dmem_data, 32'hDEADBEEF);
        dmem_r = 0;

        // Partial final word is zero-padded
        do_reset();
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        do_load(20, 0);
        dmem_r = 1; data_addr = 0; #1; check("pad_word0", dmem_data, 32'h04030201);
        data_addr = 1; #1; check("pad_word1", dmem_data, 32'h00000005);
        dmem_r = 0;

        // CPU write then read at the top address; simultaneous r/w returns old data
        cpu_access(0, 1, DEPTH - 1, 32'hCAFEF00D);
        dmem_r = 1; data_addr = ADDR_W'(DEPTH - 1); #1;
        check("top_rd", dmem_data, 32'hCAFEF00D);
        dmem_r = 0;
        cpu_access(0, 1, 3, 32'h11112222);
        dmem_r = 1; dmem_w = 1; data_addr = 3; w_data = 32'h33334444; #1;
        check("rw_old", dmem_data, 32'h11112222);
        tick();
        dmem_w = 0; #1;
        check("rw_new", dmem_data, 32'h33334444);
        ref_mem[3] = 32'h33334444;
        quiet();

        // IDLE: CPU writes ignored and reads return 0; then release with run_start
        do_reset();
        dmem_r = 1; dmem_w = 1; data_addr = 0; w_data = ~ref_mem[0]; #1;
        check("idle_rd_zero", dmem_data, 32'd0);
        tick();
        tick();
        quiet();
        run_start = 1;
        tick();
        run_start = 0;
        check("run_start_hold", 32'(cpu_hold), 32'd1);
        check("run_start_done", 32'(load_done), 32'd1);
        verify_mem(0, 3);

        // Randomized loads (sometimes with load_start and run_start together)
        for (int t = 0; t < 6; t++) begin
            do_reset();
            bq.delete();
            for (int b = 0, nb = $urandom_range(40, 1); b < nb; b++) bq.push_back(8'($urandom));
            do_load(30, 1'($urandom));
            verify_mem(0, 15);
            run_traffic(40);
        end
        verify_mem(DEPTH - 1, DEPTH - 1);

        // Reset in the middle of a load discards the partial word
        do_reset();
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_byte = 8'hAA; tick();
        load_byte = 8'hBB; tick();
        quiet();
        rst = 0; tick(); rst = 1;
        check("midrst_ready", 32'(load_ready), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_words", 32'(words_loaded), 32'd0);
        bq = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
        do_load(0, 0);
        dmem_r = 1; data_addr = 0; #1; check("restart_word0", dmem_data, 32'h0BADF00D);
        dmem_r = 0;
        verify_mem(1, 7);

        // Overfill: DEPTH*4+2 bytes
        do_reset();
        bq.delete();
        for (int b = 0; b < 4 * DEPTH + 2; b++) bq.push_back(8'($urandom));
        do_load(0, 0);
        verify_mem(0, 2);
        verify_mem(DEPTH - 3, DEPTH - 1);
        dmem_r = 1; data_addr = ADDR_W'(DEPTH - 1); #1;
        check("full_last_word", dmem_data,
              {bq[4*DEPTH-1], bq[4*DEPTH-2], bq[4*DEPTH-3], bq[4*DEPTH-4]});
        data_addr = 0; #1;
        check("full_no_wrap", dmem_data, {bq[3], bq[2], bq[1], bq[0]});
        dmem_r = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
